// File: rtl/chord_ex_arbiter_if.sv
// Requester, response and ex_top job/result signals shared by chord_ex_arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding blocks.
interface chord_ex_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             rsp_valid0;
  logic             rsp_valid1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [WIDTH-1:0] ex_out_interface;
  logic             ex_valid_out_interface;
  logic [WIDTH-1:0] ex_in_interface;
  logic             ex_valid_in_interface;

  modport slave (
    input  req0, req1, data0, data1, ex_in_interface, ex_valid_in_interface,
    output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, rsp_err,
           ex_out_interface, ex_valid_out_interface
  );

  modport master (
    output req0, req1, data0, data1, ex_in_interface, ex_valid_in_interface,
    input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, rsp_err,
           ex_out_interface, ex_valid_out_interface
  );
endinterface

// File: rtl/chord_ex_arbiter.sv
// Round-robin arbiter for two job sources sharing ex_top: forwards a fixed-length job,
// returns the results to the owner, and aborts jobs that ex_top never answers.
module chord_ex_arbiter #(
  parameter int WIDTH     = 32,
  parameter int IN_WORDS  = 1,
  parameter int OUT_WORDS = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  chord_ex_arbiter_if.slave  bus,
  output logic               stray
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0]       IN_LAST    = 4'(IN_WORDS - 1);
  localparam logic [3:0]       OUT_LAST   = 4'(OUT_WORDS - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ABORT_WORD = WIDTH'(32'hDEAD_0001);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state, state_n;
  logic             owner, owner_n;
  logic             last, last_n;
  logic [3:0]       in_cnt, in_cnt_n;
  logic [3:0]       out_cnt, out_cnt_n;
  logic [WD_W-1:0]  wd, wd_n;
  logic [WIDTH-1:0] ex_out, ex_out_n;
  logic             ex_valid, ex_valid_n;
  logic [WIDTH-1:0] rsp_data, rsp_data_n;
  logic             rsp_valid0, rsp_valid0_n;
  logic             rsp_valid1, rsp_valid1_n;
  logic             rsp_err, rsp_err_n;
  logic             stray_n;
  logic             gnt0_c, gnt1_c;
  logic             req_own;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
      wd         <= '0;
      ex_out     <= '0;
      ex_valid   <= 1'b0;
      rsp_data   <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_err    <= 1'b0;
      stray      <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last       <= last_n;
      in_cnt     <= in_cnt_n;
      out_cnt    <= out_cnt_n;
      wd         <= wd_n;
      ex_out     <= ex_out_n;
      ex_valid   <= ex_valid_n;
      rsp_data   <= rsp_data_n;
      rsp_valid0 <= rsp_valid0_n;
      rsp_valid1 <= rsp_valid1_n;
      rsp_err    <= rsp_err_n;
      stray      <= stray_n;
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_n       = last;
    in_cnt_n     = in_cnt;
    out_cnt_n    = out_cnt;
    wd_n         = wd;
    ex_out_n     = ex_out;
    ex_valid_n   = 1'b0;
    rsp_data_n   = rsp_data;
    rsp_valid0_n = 1'b0;
    rsp_valid1_n = 1'b0;
    rsp_err_n    = 1'b0;
    stray_n      = stray;
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;
    req_own      = owner ? bus.req1 : bus.req0;

    case (state)
      IDLE: begin
        if (bus.ex_valid_in_interface) stray_n = 1'b1;
        if (bus.req0 && bus.req1) begin
          owner_n = ~last;
          state_n = SEND;
        end else if (bus.req0) begin
          owner_n = 1'b0;
          state_n = SEND;
        end else if (bus.req1) begin
          owner_n = 1'b1;
          state_n = SEND;
        end
      end

      SEND: begin
        if (bus.ex_valid_in_interface) stray_n = 1'b1;
        gnt0_c = ~owner;
        gnt1_c = owner;
        if (req_own) begin
          ex_out_n   = owner ? bus.data1 : bus.data0;
          ex_valid_n = 1'b1;
          if (in_cnt == IN_LAST) begin
            in_cnt_n = '0;
            wd_n     = '0;
            state_n  = WAIT;
          end else begin
            in_cnt_n = in_cnt + 4'd1;
          end
        end
      end

      WAIT: begin
        // A result on the threshold cycle wins over the watchdog.
        if (bus.ex_valid_in_interface) begin
          rsp_data_n   = bus.ex_in_interface;
          rsp_valid0_n = ~owner;
          rsp_valid1_n = owner;
          wd_n         = '0;
          if (out_cnt == OUT_LAST) begin
            out_cnt_n = '0;
            last_n    = owner;
            state_n   = IDLE;
          end else begin
            out_cnt_n = out_cnt + 4'd1;
          end
        end else if (wd == WD_LAST) begin
          rsp_data_n   = ABORT_WORD;
          rsp_valid0_n = ~owner;
          rsp_valid1_n = owner;
          rsp_err_n    = 1'b1;
          out_cnt_n    = '0;
          last_n       = owner;
          state_n      = IDLE;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt0                   = gnt0_c;
  assign bus.gnt1                   = gnt1_c;
  assign bus.ex_out_interface       = ex_out;
  assign bus.ex_valid_out_interface = ex_valid;
  assign bus.rsp_data               = rsp_data;
  assign bus.rsp_valid0             = rsp_valid0;
  assign bus.rsp_valid1             = rsp_valid1;
  assign bus.rsp_err                = rsp_err;

endmodule

// File: tb/tb_chord_ex_arbiter.sv
// Directed bench for chord_ex_arbiter with IN_WORDS=2, OUT_WORDS=1, TIMEOUT=8.
// Inputs change #1 after each rising edge; outputs are sampled at the same point.
module tb_chord_ex_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic stray;
  int   compared = 0;
  int   mismatched = 0;
  logic gnt1_seen;
  logic rsp_seen;
  int   n;

  chord_ex_arbiter_if #(.WIDTH(32)) bus();

  chord_ex_arbiter #(
    .WIDTH(32), .IN_WORDS(2), .OUT_WORDS(1), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .stray(stray)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    gnt1_seen = gnt1_seen | bus.gnt1;
    rsp_seen  = rsp_seen | bus.rsp_valid0 | bus.rsp_valid1;
  endtask

  // The non-owner always presents a different word so a wrong data mux shows up.
  task automatic set_words(input int who, input logic [31:0] w);
    bus.data0 = (who == 0) ? w : (w ^ 32'hFFFF_0000);
    bus.data1 = (who == 1) ? w : (w ^ 32'hFFFF_0000);
  endtask

  task automatic do_reset();
    bus.req0 = 0; bus.req1 = 0;
    bus.data0 = 0; bus.data1 = 0;
    bus.ex_in_interface = 0; bus.ex_valid_in_interface = 0;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  // One full 2-word job; result returned after 'delay' idle WAIT cycles.
  task automatic applyStimulus(input int who, input bit tie, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] r, input int delay);
    logic [1:0] hot;
    hot = (who == 1) ? 2'b10 : 2'b01;
    bus.req0 = tie || (who == 0);
    bus.req1 = tie || (who == 1);
    set_words(who, w0);
    step();
    checkOutput("grant", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, hot});
    step();
    checkOutput("word0_valid", {31'd0, bus.ex_valid_out_interface}, 32'd1);
    checkOutput("word0_data", bus.ex_out_interface, w0);
    set_words(who, w1);
    step();
    checkOutput("word1_valid", {31'd0, bus.ex_valid_out_interface}, 32'd1);
    checkOutput("word1_data", bus.ex_out_interface, w1);
    checkOutput("wait_no_grant", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    if (!tie) begin
      bus.req0 = 0; bus.req1 = 0;
    end
    for (int i = 0; i < delay; i++) step();
    bus.ex_valid_in_interface = 1;
    bus.ex_in_interface = r;
    step();
    bus.ex_valid_in_interface = 0;
    checkOutput("rsp_route", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, {30'd0, hot});
    checkOutput("rsp_data", bus.rsp_data, r);
    checkOutput("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
  endtask

  initial begin
    gnt1_seen = 0;
    rsp_seen  = 0;
    do_reset();
    checkOutput("rst_flags", {25'd0, bus.gnt1, bus.gnt0, bus.rsp_valid1, bus.rsp_valid0,
                bus.rsp_err, bus.ex_valid_out_interface, stray}, 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'd0);
    checkOutput("rst_ex_out", bus.ex_out_interface, 32'd0);
    checkOutput("rst_rsp_data", bus.rsp_data, 32'd0);

    $display("[TB] single job");
    gnt1_seen = 0;
    applyStimulus(0, 0, 32'h11, 32'h22, 32'h99, 4);
    checkOutput("single_gnt1_quiet", {31'd0, gnt1_seen}, 32'd0);

    $display("[TB] tie round-robin");
    do_reset();
    applyStimulus(0, 1, 32'hA0, 32'hA1, 32'hB0, 1);
    applyStimulus(1, 1, 32'hC0, 32'hC1, 32'hD0, 1);
    applyStimulus(0, 1, 32'hE0, 32'hE1, 32'hF0, 1);
    bus.req0 = 0; bus.req1 = 0;

    $display("[TB] stall");
    bus.req0 = 1;
    set_words(0, 32'h33);
    step();
    step();
    checkOutput("stall_w0", bus.ex_out_interface, 32'h33);
    bus.req0 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_no_strobe", {31'd0, bus.ex_valid_out_interface}, 32'd0);
      checkOutput("stall_state", 32'(dut.state), 32'd1);
    end
    bus.req0 = 1;
    set_words(0, 32'h44);
    step();
    bus.req0 = 0;
    checkOutput("stall_w1_valid", {31'd0, bus.ex_valid_out_interface}, 32'd1);
    checkOutput("stall_w1_data", bus.ex_out_interface, 32'h44);
    bus.ex_valid_in_interface = 1;
    bus.ex_in_interface = 32'h55;
    step();
    bus.ex_valid_in_interface = 0;
    checkOutput("stall_rsp", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd1);
    checkOutput("stall_rsp_data", bus.rsp_data, 32'h55);

    $display("[TB] timeout");
    bus.req0 = 1;
    set_words(0, 32'h66);
    step();
    step();
    set_words(0, 32'h77);
    step();
    bus.req0 = 0;
    n = 1;
    while (!bus.rsp_valid0 && n < 20) begin
      step();
      n++;
    end
    checkOutput("abort_latency", 32'(n), 32'd9);
    checkOutput("abort_err", {31'd0, bus.rsp_err}, 32'd1);
    checkOutput("abort_data", bus.rsp_data, 32'hDEAD_0001);
    checkOutput("abort_stray_clear", {31'd0, stray}, 32'd0);
    bus.ex_valid_in_interface = 1;
    bus.ex_in_interface = 32'hAB;
    step();
    bus.ex_valid_in_interface = 0;
    checkOutput("late_stray", {31'd0, stray}, 32'd1);
    checkOutput("late_no_rsp", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);

    $display("[TB] timeout edge");
    do_reset();
    bus.req0 = 1;
    set_words(0, 32'h81);
    step();
    step();
    set_words(0, 32'h82);
    step();
    bus.req0 = 0;
    rsp_seen = 0;
    for (int i = 0; i < 7; i++) step();
    checkOutput("edge_quiet", {31'd0, rsp_seen}, 32'd0);
    bus.ex_valid_in_interface = 1;
    bus.ex_in_interface = 32'h5A;
    step();
    bus.ex_valid_in_interface = 0;
    checkOutput("edge_rsp", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd1);
    checkOutput("edge_err", {31'd0, bus.rsp_err}, 32'd0);
    checkOutput("edge_data", bus.rsp_data, 32'h5A);
    step();
    checkOutput("edge_no_abort", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);

    $display("[TB] reset mid-WAIT");
    bus.req0 = 1;
    set_words(0, 32'h10);
    step();
    step();
    set_words(0, 32'h20);
    step();
    bus.req0 = 0;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    checkOutput("mid_rst_flags", {25'd0, bus.gnt1, bus.gnt0, bus.rsp_valid1, bus.rsp_valid0,
                bus.rsp_err, bus.ex_valid_out_interface, stray}, 32'd0);
    checkOutput("mid_rst_data", bus.rsp_data | bus.ex_out_interface, 32'd0);
    checkOutput("mid_rst_state", 32'(dut.state), 32'd0);
    rsp_seen = 0;
    bus.ex_valid_in_interface = 1;
    bus.ex_in_interface = 32'h77;
    step();
    bus.ex_valid_in_interface = 0;
    checkOutput("mid_rst_stray", {31'd0, stray}, 32'd1);
    bus.req0 = 1; bus.req1 = 1;
    step();
    checkOutput("mid_rst_tie", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    checkOutput("mid_rst_no_rsp", {31'd0, rsp_seen}, 32'd0);
    bus.req0 = 0; bus.req1 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
